conv_relu_pool: RTL and testbench

//  Downstream stage of the conv PE (conv_pe_sr). Takes the PE's raster-ordered stream of signed
//  2*WIDTH-bit convolution sums, one per valid cycle. Applies ReLU, then 2x2/stride-2 max pooling

---
 rtl/conv_relu_pool.sv | 81 ++++++++
 tb/tb_conv_relu_pool.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/conv_relu_pool.sv
// ReLU followed by 2x2/stride-2 max pooling over a raster-ordered stream of conv sums.
// A half-row line buffer holds the horizontal pair maxima of each even row.
module conv_relu_pool #(
  parameter int WIDTH   = 9,
  parameter int ROW_LEN = 30,
  parameter int ADDR_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [2*WIDTH-1:0]   data_in,
  output logic                 out_valid,
  output logic                 out_eol,
  output logic [2*WIDTH-1:0]   data_out
);

  localparam int DW    = 2 * WIDTH;
  localparam int COL_W = (ROW_LEN > 2) ? $clog2(ROW_LEN) : 1;
  localparam int DEPTH = ROW_LEN / 2;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_LEN - 1);

  function automatic logic [DW-1:0] umax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a >= b) ? a : b;
  endfunction

  logic [COL_W-1:0]  col, eff_col;
  logic              row_odd, eff_row_odd;
  logic [DW-1:0]     hreg, relu, h, lb_rd, pooled;
  logic [ADDR_W-1:0] lb_addr;
  logic              lb_we;
  logic [DW-1:0]     lbuf [DEPTH];

  // A start-of-frame sample overrides the running position, discarding any partial frame.
  always_comb begin
    eff_col     = in_sof ? '0 : col;
    eff_row_odd = in_sof ? 1'b0 : row_odd;
    relu        = data_in[DW-1] ? '0 : data_in;
    h           = umax(hreg, relu);
    lb_addr     = ADDR_W'(eff_col >> 1);
    lb_rd       = lbuf[lb_addr];
    pooled      = umax(h, lb_rd);
    lb_we       = in_valid & eff_col[0] & ~eff_row_odd;
  end

  // NOTE: the line buffer has no reset; every entry is written on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (lb_we) lbuf[lb_addr] <= h;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_eol   <= 1'b0;
      data_out  <= '0;
      col       <= '0;
      row_odd   <= 1'b0;
      hreg      <= '0;
    end else begin
      out_valid <= 1'b0;
      out_eol   <= 1'b0;
      if (in_valid) begin
        if (!eff_col[0]) begin
          hreg <= relu;
        end else if (eff_row_odd) begin
          data_out  <= pooled;
          out_valid <= 1'b1;
          out_eol   <= (eff_col == LAST_COL);
        end
        if (eff_col == LAST_COL) begin
          col     <= '0;
          row_odd <= ~eff_row_odd;
        end else begin
          col     <= eff_col + COL_W'(1);
          row_odd <= eff_row_odd;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_relu_pool.sv
// Directed bench for conv_relu_pool with ROW_LEN=4: expected pooled values are queued as the
// completing sample is driven and compared (value, eol, arrival cycle) when out_valid pulses.
module tb_conv_relu_pool;

  localparam int WIDTH   = 9;
  localparam int ROW_LEN = 4;
  localparam int ADDR_W  = 1;
  localparam int DW      = 2 * WIDTH;

  typedef struct {
    int unsigned   cyc;
    logic [DW-1:0] d;
    logic          eol;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_sof;
  logic [DW-1:0] data_in;
  logic          out_valid;
  logic          out_eol;
  logic [DW-1:0] data_out;

  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  exp_t        sb[$];

  conv_relu_pool #(.WIDTH(WIDTH), .ROW_LEN(ROW_LEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .data_in(data_in),
    .out_valid(out_valid), .out_eol(out_eol), .data_out(data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard side: every output pulse must match the head of the queue, on its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        e = sb.pop_front();
        check("data", data_out, e.d);
        check("eol", out_eol, e.eol);
        check("latency_cycle", cyc, e.cyc);
        check("msb_zero", data_out[DW-1], 0);
      end
    end
  end

  task automatic send(input int d, input bit sof = 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    data_in  = DW'(d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      data_in  = '0;
    end
  endtask

  // Called right after the completing sample is driven: it is sampled on the next edge.
  task automatic expect_out(input int d, input bit eol);
    exp_t e;
    e.cyc = cyc + 1;
    e.d   = DW'(d);
    e.eol = eol;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    idle(4);
    check(tag, sb.size(), 0);
    sb.delete();
  endtask

  task automatic frame_1_7(input bit sof, input int gap);
    send(1, sof); idle(gap); send(5); idle(gap); send(3); idle(gap); send(2); idle(gap);
    send(4); idle(gap); send(0); expect_out(5, 1'b0); idle(gap);
    send(7); idle(gap); send(6); expect_out(7, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_data_out", data_out, 0);
    check("reset_out_eol", out_eol, 0);
    rst_n = 1'b1;
    idle(2);

    // 1: basic pooling
    frame_1_7(1'b1, 0);
    drain("t1_drain");

    // 2: ReLU, all-negative window and max positive value
    send(-3, 1'b1); send(-1); send(-7); send(-2);
    send(-5); send(-4); expect_out(0, 1'b0); send(2); send(-1); expect_out(2, 1'b1);
    send(131071, 1'b1); send(0); send(0); send(-1);
    send(-1); send(-1); expect_out(131071, 1'b0); send(-5); send(131071); expect_out(131071, 1'b1);
    drain("t2_drain");

    // 3: two-cycle bubbles between every sample
    frame_1_7(1'b1, 2);
    drain("t3_drain");

    // 4: partial frame abandoned by a new in_sof
    send(9, 1'b1); send(9); send(9);
    frame_1_7(1'b1, 0);
    drain("t4_drain");

    // 5: asynchronous reset mid-frame, then refeed without in_sof
    send(1, 1'b1); send(5); send(3); send(2); send(4);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_data_out", data_out, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    frame_1_7(1'b0, 0);
    drain("t5_drain");

    // 6: four rows, 0..15 raster; second pooled row reuses the line buffer
    for (int i = 0; i < 16; i++) begin
      send(i, i == 0);
      if (i == 5)  expect_out(5, 1'b0);
      if (i == 7)  expect_out(7, 1'b1);
      if (i == 13) expect_out(13, 1'b0);
      if (i == 15) expect_out(15, 1'b1);
    end
    drain("t6_drain");
    check("final_data_out", data_out, 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
